// File: rtl/path_chk.sv
// Maze-path checker: validates a stream of (x,y) beats from (0,0) to (15,15) in unit steps.
// Define PATH_CHK_READBACK_EN to add the 256-entry capture buffer and READ state.
module path_chk (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  input  logic       maze_not_valid,
  input  logic       rd_req,
  output logic       done,
  output logic       path_ok,
  output logic [2:0] err_code,
  output logic [8:0] path_len,
  output logic       rd_valid,
  output logic       rd_last,
  output logic [3:0] rd_x,
  output logic [3:0] rd_y,
  output logic       busy
);

  localparam logic [8:0] DEPTH = 9'd256;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_START    = 3'd1,
    ERR_STEP     = 3'd2,
    ERR_END      = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_NOPATH   = 3'd5
  } err_e;

`ifdef PATH_CHK_READBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VERDICT, S_READ} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VERDICT} state_e;
`endif

  state_e     state_q, state_d;
  err_e       err_q, err_d;
  logic [8:0] len_q, len_d;
  logic [3:0] prev_x_q, prev_x_d;
  logic [3:0] prev_y_q, prev_y_d;
  logic       done_q, done_d;

  logic       start, store, nopath;
  logic [3:0] adx, ady;
  logic       step_bad, end_bad;

  // Manhattan distance to the previously stored beat must be exactly one.
  assign adx      = (in_x >= prev_x_q) ? (in_x - prev_x_q) : (prev_x_q - in_x);
  assign ady      = (in_y >= prev_y_q) ? (in_y - prev_y_q) : (prev_y_q - in_y);
  assign step_bad = (({1'b0, adx} + {1'b0, ady}) != 5'd1);
  assign end_bad  = (prev_x_q != 4'hF) || (prev_y_q != 4'hF);

`ifdef PATH_CHK_READBACK_EN
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       rd_fire, rd_is_last;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] mem [256];
  logic [7:0] rd_data_q;

  assign rd_is_last = ({1'b0, rd_ptr_q} == (len_q - 9'd1));
  assign wr_en      = start | store;
  assign wr_addr    = start ? 8'd0 : len_q[7:0];
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    len_d    = len_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    done_d   = 1'b0;
    start    = 1'b0;
    store    = 1'b0;
    nopath   = 1'b0;
`ifdef PATH_CHK_READBACK_EN
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_fire    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (maze_not_valid)  nopath = 1'b1;
        else if (in_valid)   start  = 1'b1;
      end
      S_COLLECT: begin
        if (maze_not_valid) begin
          nopath = 1'b1;
        end else if (in_valid) begin
          if (len_q == DEPTH) begin
            if (err_q == ERR_OK) err_d = ERR_OVERFLOW;
          end else begin
            store = 1'b1;
            if (err_q == ERR_OK && step_bad) err_d = ERR_STEP;
          end
        end else begin
          state_d = S_VERDICT;
          done_d  = 1'b1;
          if (err_q == ERR_OK && end_bad) err_d = ERR_END;
        end
      end
      S_VERDICT: begin
`ifdef PATH_CHK_READBACK_EN
        if (len_q != '0) begin
          state_d  = S_READ;
          rd_ptr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
`ifdef PATH_CHK_READBACK_EN
      S_READ: begin
        if (maze_not_valid) begin
          nopath = 1'b1;
        end else if (in_valid) begin
          start = 1'b1;
        end else if (rd_req) begin
          rd_fire    = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = rd_is_last;
          rd_ptr_d   = rd_ptr_q + 8'd1;
          if (rd_is_last) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Shared actions; a new path may start from IDLE or abort an ongoing readback.
    if (nopath) begin
      state_d = S_VERDICT;
      err_d   = ERR_NOPATH;
      len_d   = '0;
      done_d  = 1'b1;
    end
    if (start) begin
      state_d  = S_COLLECT;
      len_d    = 9'd1;
      err_d    = (in_x != '0 || in_y != '0) ? ERR_START : ERR_OK;
      prev_x_d = in_x;
      prev_y_d = in_y;
    end
    if (store) begin
      len_d    = len_q + 9'd1;
      prev_x_d = in_x;
      prev_y_d = in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_OK;
      len_q    <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      done_q   <= 1'b0;
`ifdef PATH_CHK_READBACK_EN
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      len_q    <= len_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      done_q   <= done_d;
`ifdef PATH_CHK_READBACK_EN
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
`endif
    end
  end

  assign done     = done_q;
  assign err_code = err_q;
  assign path_ok  = done_q && (err_q == ERR_OK);
  assign path_len = len_q;

`ifdef PATH_CHK_READBACK_EN
  // Buffer has no reset; rd_x/rd_y are masked by rd_valid so reset still drives them to 0.
  always_ff @(posedge clk) begin
    if (wr_en)   mem[wr_addr] <= {in_x, in_y};
    if (rd_fire) rd_data_q    <= mem[rd_ptr_q];
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_x     = rd_valid_q ? rd_data_q[7:4] : '0;
  assign rd_y     = rd_valid_q ? rd_data_q[3:0] : '0;
  assign busy     = (state_q == S_COLLECT) || (state_q == S_READ);
`else
  logic unused_rd_req;
  assign unused_rd_req = rd_req;
  assign rd_valid      = 1'b0;
  assign rd_last       = 1'b0;
  assign rd_x          = '0;
  assign rd_y          = '0;
  assign busy          = (state_q == S_COLLECT);
`endif

endmodule

// File: tb/tb_path_chk.sv
// Self-checking bench for path_chk: vector table, hand-written corner sequences and random paths
// checked against a path-level reference model.
module tb_path_chk;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_x, in_y;
  logic       maze_not_valid;
  logic       rd_req;
  logic       done, path_ok;
  logic [2:0] err_code;
  logic [8:0] path_len;
  logic       rd_valid, rd_last;
  logic [3:0] rd_x, rd_y;
  logic       busy;

  path_chk dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_x           (in_x),
    .in_y           (in_y),
    .maze_not_valid (maze_not_valid),
    .rd_req         (rd_req),
    .done           (done),
    .path_ok        (path_ok),
    .err_code       (err_code),
    .path_len       (path_len),
    .rd_valid       (rd_valid),
    .rd_last        (rd_last),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } beat_t;

  typedef struct {
    string name;
    int    n;
    int    sx;
    int    sy;
    int    idx;
    int    kind;     // 0 none, 1 repeat previous, 2 diagonal, 3 jump +3 in x
    int    exp_err;
    int    exp_len;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t stair(input int i);
    beat_t b;
    b.x = 4'((i + 1) / 2);
    b.y = 4'(i / 2);
    return b;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: errors in time order -- start beat, first bad step, 257th beat, final beat.
  function automatic int model_err(input beat_t p[$]);
    int kept;
    kept = (p.size() > 256) ? 256 : p.size();
    if (p[0].x != 0 || p[0].y != 0) return 1;
    for (int i = 1; i < kept; i++)
      if (iabs(int'(p[i].x) - int'(p[i-1].x)) + iabs(int'(p[i].y) - int'(p[i-1].y)) != 1)
        return 2;
    if (p.size() > 256) return 4;
    if (p[kept-1].x != 15 || p[kept-1].y != 15) return 3;
    return 0;
  endfunction

  task automatic build_vec(input vec_t v, output beat_t p[$]);
    beat_t b;
    p.delete();
    for (int i = 0; i < v.n; i++) begin
      b = stair(i);
      if (i == 0) begin
        b.x = 4'(v.sx);
        b.y = 4'(v.sy);
      end
      if (i == v.idx) begin
        case (v.kind)
          1: b = p[i-1];
          2: begin b.x = p[i-1].x + 4'd1; b.y = p[i-1].y + 4'd1; end
          3: begin b.x = p[i-1].x + 4'd3; b.y = p[i-1].y; end
          default: ;
        endcase
      end
      p.push_back(b);
    end
  endtask

  task automatic run_path(input beat_t p[$], input int exp_err, input int exp_len,
                          input int n_read, input string tag);
    int early, busy_bad, mism, kept;
    early = 0; busy_bad = 0; mism = 0; kept = exp_len;
    foreach (p[i]) begin
      in_valid = 1'b1;
      in_x     = p[i].x;
      in_y     = p[i].y;
      step();
      if (done !== 1'b0) early++;
      if (busy !== 1'b1) busy_bad++;
    end
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    chk({tag, ":early_done"}, early, 0);
    chk({tag, ":busy"}, busy_bad, 0);
    step();
    chk({tag, ":done"}, done, 1);
    chk({tag, ":err"}, err_code, exp_err);
    chk({tag, ":path_ok"}, path_ok, (exp_err == 0));
    chk({tag, ":len"}, path_len, exp_len);
    step();
    chk({tag, ":done_1cyc"}, done, 0);
    chk({tag, ":len_held"}, path_len, exp_len);
`ifdef PATH_CHK_READBACK_EN
    for (int i = 0; i < n_read && i < kept; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd_req = 1'b0;
        step();
        if (rd_valid !== 1'b0) mism++;
      end
      rd_req = 1'b1;
      step();
      if (rd_valid !== 1'b1 || rd_x !== p[i].x || rd_y !== p[i].y || rd_last !== (i == kept - 1))
        mism++;
    end
    rd_req = 1'b0;
    if (n_read >= kept) begin
      rd_req = 1'b1;
      step();
      if (rd_valid !== 1'b0 || busy !== 1'b0) mism++;
      rd_req = 1'b0;
    end
    chk({tag, ":readback"}, mism, 0);
`else
    rd_req = 1'b1;
    repeat (3) begin
      step();
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_x !== 4'd0 || rd_y !== 4'd0) mism++;
    end
    rd_req = 1'b0;
    chk({tag, ":no_readback"}, mism, 0);
`endif
  endtask

  vec_t  vt[10];
  beat_t p[$];
  beat_t b;

  initial begin
    int bad;
    vt[0] = '{"legal31",     31,  0,  0, -1, 0, 0, 31};
    vt[1] = '{"short20",     20,  0,  0, -1, 0, 3, 20};
    vt[2] = '{"start10",     31,  1,  0, -1, 0, 1, 31};
    vt[3] = '{"repeat10",    31,  0,  0, 10, 1, 2, 31};
    vt[4] = '{"diag12",      31,  0,  0, 12, 2, 2, 31};
    vt[5] = '{"jump5",       31,  0,  0,  5, 3, 2, 31};
    vt[6] = '{"one00",        1,  0,  0, -1, 0, 3,  1};
    vt[7] = '{"oneFF",        1, 15, 15, -1, 0, 1,  1};
    vt[8] = '{"repeat_last", 31,  0,  0, 30, 1, 2, 31};
    vt[9] = '{"start_diag",  31,  1,  0,  7, 2, 1, 31};

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; maze_not_valid = 1'b0; rd_req = 1'b0;
    step();
    step();
    chk("reset_done", done, 0);
    chk("reset_path_ok", path_ok, 0);
    chk("reset_err", err_code, 0);
    chk("reset_len", path_len, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd", {rd_valid, rd_last, rd_x, rd_y}, 0);
    rst_n = 1'b1;
    step();

    foreach (vt[i]) begin
      build_vec(vt[i], p);
      run_path(p, vt[i].exp_err, vt[i].exp_len, 1000, vt[i].name);
    end

    // maze_not_valid while idle
    maze_not_valid = 1'b1;
    step();
    maze_not_valid = 1'b0;
    chk("nopath_done", done, 1);
    chk("nopath_ok", path_ok, 0);
    chk("nopath_err", err_code, 5);
    chk("nopath_len", path_len, 0);
    rd_req = 1'b1;
    step();
    chk("nopath_no_read", {done, busy}, 0);
    step();
    chk("nopath_no_rdvalid", rd_valid, 0);
    rd_req = 1'b0;

    // maze_not_valid and in_valid together
    maze_not_valid = 1'b1; in_valid = 1'b1; in_x = '0; in_y = '0;
    step();
    maze_not_valid = 1'b0; in_valid = 1'b0;
    chk("both_done", done, 1);
    chk("both_err", err_code, 5);
    chk("both_len", path_len, 0);
    step();
    chk("both_idle", {done, busy}, 0);

    // maze_not_valid aborting a collection
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; b = stair(i); in_x = b.x; in_y = b.y;
      step();
    end
    in_valid = 1'b0; maze_not_valid = 1'b1;
    step();
    maze_not_valid = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_err", err_code, 5);
    step();
    chk("abort_idle", {done, busy}, 0);

    // asynchronous reset on beat 10 of a collection
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; b = stair(i); in_x = b.x; in_y = b.y;
      step();
    end
    b = stair(9); in_x = b.x; in_y = b.y;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {done, path_ok, err_code, path_len, rd_valid, rd_last, rd_x, rd_y, busy}, 0);
    in_valid = 1'b0;
    bad = 0;
    repeat (2) begin
      step();
      if (done !== 1'b0) bad++;
    end
    #2 rst_n = 1'b1;
    step();
    if (done !== 1'b0 || busy !== 1'b0) bad++;
    chk("rst_no_done", bad, 0);
    build_vec(vt[0], p);
    run_path(p, 0, 31, 1000, "after_rst");

    // 300 beats: overflow, first 256 kept
    p.delete();
    for (int i = 0; i < 300; i++) begin
      if (i <= 30) b = stair(i);
      else begin b.x = 4'd15; b.y = (i % 2 == 0) ? 4'd15 : 4'd14; end
      p.push_back(b);
    end
    run_path(p, 4, 256, 256, "overflow");

`ifdef PATH_CHK_READBACK_EN
    // new path during readback aborts it
    build_vec(vt[0], p);
    run_path(p, 0, 31, 3, "partial_read");
    build_vec(vt[3], p);
    run_path(p, 2, 31, 1000, "abort_read");
`endif

    // random paths against the reference model
    for (int r = 0; r < 40; r++) begin
      p.delete();
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 31; i++) p.push_back(stair(i));
        if ($urandom_range(0, 1) == 0) begin
          b.x = 4'($urandom_range(0, 15));
          b.y = 4'($urandom_range(0, 15));
          p[$urandom_range(0, 30)] = b;
        end
      end else begin
        int n;
        n = $urandom_range(1, 40);
        if ($urandom_range(0, 3) == 0) begin
          b.x = 4'($urandom_range(0, 15)); b.y = 4'($urandom_range(0, 15));
        end else begin
          b = '0;
        end
        p.push_back(b);
        for (int i = 1; i < n; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            b.x = 4'($urandom_range(0, 15)); b.y = 4'($urandom_range(0, 15));
          end else begin
            case ($urandom_range(0, 3))
              0: b.x = (b.x < 15) ? b.x + 4'd1 : b.x - 4'd1;
              1: b.x = (b.x > 0)  ? b.x - 4'd1 : b.x + 4'd1;
              2: b.y = (b.y < 15) ? b.y + 4'd1 : b.y - 4'd1;
              default: b.y = (b.y > 0) ? b.y - 4'd1 : b.y + 4'd1;
            endcase
          end
          p.push_back(b);
        end
      end
      run_path(p, model_err(p), (p.size() > 256) ? 256 : p.size(), 1000,
               $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
